// File: rtl/uart_rx_os16_if.sv
// Handshake bundle between the baud generator / serial line / consumer and the 16x UART receiver.
// The slave modport is the receiver's view; master is the driving environment.
interface uart_rx_os16_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 clken;
  logic                 rx;
  logic                 rdy_clr;
  logic [DATA_BITS-1:0] data;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output clken, rx, rdy_clr,
    input  data, rdy, frame_err, overrun
  );

  modport slave (
    input  clken, rx, rdy_clr,
    output data, rdy, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver driven by a 16x oversample enable: mid-bit start validation, LSB-first
// data capture, stop-bit check, ready/clear handshake with sticky framing and overrun flags.
module uart_rx_os16 #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             clk_50m,
  input logic             rst_n,
  uart_rx_os16_if.slave   bus
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TickW-1:0]       tick_q, tick_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   rdy_q, rdy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_s;
  logic                   good_frame;
  logic                   bad_frame;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Line synchroniser runs every cycle; resets to idle-high so reset does not fake a start.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else if (SYNC_STAGES > 1) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    good_frame = 1'b0;
    bad_frame  = 1'b0;

    if (bus.clken) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d = StStart;
            tick_d  = '0;
          end
        end
        StStart: begin
          if (tick_q == TickHalf) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? StIdle : StData;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StData: begin
          if (tick_q == TickLast) begin
            shift_d[bit_q] = rx_s;
            tick_d         = '0;
            if (bit_q == BitLast) begin
              bit_d   = '0;
              state_d = StStop;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StStop: begin
          if (tick_q == TickLast) begin
            tick_d = '0;
            if (rx_s) begin
              good_frame = 1'b1;
              state_d    = StIdle;
            end else begin
              bad_frame = 1'b1;
              state_d   = StWaitHigh;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StWaitHigh: begin
          // A held-low break must see the line return high before a new start is accepted.
          if (rx_s) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          tick_d  = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    data_d      = data_q;
    rdy_d       = rdy_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (bus.rdy_clr) begin
      rdy_d       = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    // Completion overrides a simultaneous clear; overrun only if the old byte was never taken.
    if (good_frame) begin
      data_d      = shift_q;
      rdy_d       = 1'b1;
      frame_err_d = 1'b0;
      if (rdy_q && !bus.rdy_clr) begin
        overrun_d = 1'b1;
      end
    end

    if (bad_frame) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART receiver, 8N1, directly downstream of the baud-rate generator.
- Consumes the generator's 16x-oversampled Rx enable pulse (one clk_50m cycle wide, every 27 cycles at 115200 baud).
- Synchronises the serial line, validates the start bit at mid-bit, samples data LSB first, checks the stop bit.
- Presents the received byte with a ready/clear handshake, plus framing-error and overrun flags.

Parameters:
- DATA_BITS, 8, data bits per frame (LSB first).
- OVERSAMPLE, 16, clken ticks per bit period; must be even and at least 4.
- SYNC_STAGES, 2, number of synchroniser flops on rx; minimum 2.

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- clken  in  1  oversample enable from baud generator (Rxclk_en); single-cycle pulse.
- rx  in  1  asynchronous serial input; idle high.
- rdy_clr  in  1  consumer acknowledge; clears rdy, overrun and frame_err.
- data  out  DATA_BITS  last good received byte.
- rdy  out  1  a new byte is available.
- frame_err  out  1  sticky: stop bit was sampled low.
- overrun  out  1  sticky: a byte completed while rdy was still set.

Behaviour:
Reset:
- Asynchronous on rst_n=0.
- data=0, rdy=0, frame_err=0, overrun=0.
- Synchroniser flops=1; state=IDLE; tick counter=0; bit index=0; shift register=0.

Synchroniser:
- rx passes through SYNC_STAGES flops on clk_50m, ungated by clken; the output is rx_s.

Timing:
- The FSM, tick counter, bit index and shift register change only on cycles with clken=1.
- Output flag updates and rdy_clr handling occur on the same clk_50m edge.

IDLE:
- On a clken tick with rx_s=0: go to START, tick counter=0.

START:
- Each clken tick increments the tick counter.
- On the tick where the counter reaches OVERSAMPLE/2-1 (the 8th tick after detection, at mid start bit), check rx_s.
- rx_s=0: go to DATA, tick counter=0, bit index=0.
- rx_s=1: false start; go to IDLE; no flag changes.

DATA:
- Each clken tick increments the tick counter.
- On the tick where it reaches OVERSAMPLE-1: shift register[bit index]=rx_s, tick counter=0, bit index+1.
- After bit index DATA_BITS-1 is sampled: go to STOP.

STOP:
- On the tick where the counter reaches OVERSAMPLE-1, sample rx_s.
- rx_s=1, good frame:
  - data=shift register; rdy=1; frame_err=0.
  - overrun=1 if rdy was already 1 and rdy_clr is not asserted that cycle.
  - Go to IDLE.
- rx_s=0, framing error or break:
  - frame_err=1; data and rdy unchanged; overrun unchanged.
  - Go to WAIT_HIGH.

WAIT_HIGH:
- On a clken tick with rx_s=1: go to IDLE.
- This prevents a held-low break from re-triggering a start.

rdy_clr:
- Sampled on every clk_50m cycle, not gated by clken.
- Clears rdy, overrun and frame_err next edge.
- If a good frame completes in the same cycle: rdy=1, data updated, overrun=0, frame_err=0. Completion wins over clear for rdy.

Counters and widths:
- Tick counter width is $clog2(OVERSAMPLE).
- Bit index width is $clog2(DATA_BITS) or at least 1 bit.
- The tick counter never wraps past OVERSAMPLE-1.

Other boundaries:
- rx toggling while in DATA or STOP does not affect state except through samples.
- clken held high continuously is legal; every cycle then counts as one tick.
- rst_n asserted mid-frame: immediate return to reset values. After release, the FSM waits for a fresh falling edge in IDLE; if rx_s is low at release, this counts as a start detect.
- Latency: rdy rises on the clk_50m edge of the clken tick at mid stop bit, plus SYNC_STAGES cycles of line delay.

Test Plan:
- Bench setup: clken every 27 cycles; bit time 432 cycles.
- Good byte: drive rx 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rdy=1 about 9.5 bit times after the start edge; data=0xA5; frame_err=0; overrun=0; rdy_clr pulse -> rdy=0.
- False start: rx low for 81 cycles (3 ticks), then high -> FSM back to IDLE; rdy stays 0. A following 0x3C frame is received correctly.
- Framing error: send 0x3C with the stop bit low, then hold rx low for 2 bit times, then high -> frame_err=1; data keeps its previous value; rdy unchanged; no new start until rx is high. Next good 0x81 -> data=0x81, frame_err=0.
- Overrun: send 0x11 then 0x22 without rdy_clr -> data=0x22, rdy=1, overrun=1. rdy_clr -> rdy=0, overrun=0.
- Clear collision: assert rdy_clr on the exact cycle the second byte 0x55 completes while rdy=1 -> rdy=1, data=0x55, overrun=0.
- Reset mid-frame: pull rst_n low during data bit 4 of 0xF0 -> all outputs 0 immediately. After release with rx idle high, send 0x0F -> data=0x0F, rdy=1.
